// File: rtl/la_axis_up_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : la_axis_up_arbiter
// Brief    : Packet-aware two-source AXI-Stream arbiter for the shared upstream
//            link (LA trace with high-priority request, user-project stream).
// Revision : 1.0 - initial release
// ============================================================================
module la_axis_up_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 2
) (
    input  logic                    axis_clk,
    input  logic                    axis_rst,
    input  logic                    cfg_arb_en,
    input  logic [7:0]              cfg_starve_lim,

    input  logic [DATA_WIDTH-1:0]   s0_tdata,
    input  logic [DATA_WIDTH/8-1:0] s0_tstrb,
    input  logic [DATA_WIDTH/8-1:0] s0_tkeep,
    input  logic [USER_WIDTH-1:0]   s0_tuser,
    input  logic                    s0_tlast,
    input  logic                    s0_tvalid,
    input  logic                    s0_hpri_req,
    output logic                    s0_tready,

    input  logic [DATA_WIDTH-1:0]   s1_tdata,
    input  logic [DATA_WIDTH/8-1:0] s1_tstrb,
    input  logic [DATA_WIDTH/8-1:0] s1_tkeep,
    input  logic [USER_WIDTH-1:0]   s1_tuser,
    input  logic                    s1_tlast,
    input  logic                    s1_tvalid,
    output logic                    s1_tready,

    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tstrb,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic [USER_WIDTH-1:0]   m_tuser,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    output logic                    m_tid,
    input  logic                    m_tready,

    output logic [1:0]              grant_state
);

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_GNT0 = 2'b01;
    localparam logic [1:0] c_GNT1 = 2'b10;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic                    r_last_gnt;
    logic [7:0]              r_starve_cnt;

    logic [DATA_WIDTH-1:0]   r_m_tdata;
    logic [DATA_WIDTH/8-1:0] r_m_tstrb;
    logic [DATA_WIDTH/8-1:0] r_m_tkeep;
    logic [USER_WIDTH-1:0]   r_m_tuser;
    logic                    r_m_tlast;
    logic                    r_m_tvalid;
    logic                    r_m_tid;

    logic                    w_out_free;
    logic                    w_acc0;
    logic                    w_acc1;
    logic                    w_done0;
    logic                    w_done1;
    logic                    w_starve;

    // The output register can take a new beat when empty or draining this cycle.
    assign w_out_free = !r_m_tvalid || m_tready;
    assign s0_tready  = (r_state == c_GNT0) && w_out_free;
    assign s1_tready  = (r_state == c_GNT1) && w_out_free;
    assign w_acc0     = s0_tvalid && s0_tready;
    assign w_acc1     = s1_tvalid && s1_tready;
    assign w_done0    = w_acc0 && s0_tlast;
    assign w_done1    = w_acc1 && s1_tlast;
    assign w_starve   = (cfg_starve_lim != 8'd0) && (r_starve_cnt >= cfg_starve_lim) && s1_tvalid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (cfg_arb_en) begin
                    if (w_starve) begin
                        w_state_nxt = c_GNT1;
                    end else if (s0_tvalid && s0_hpri_req) begin
                        w_state_nxt = c_GNT0;
                    end else if (s0_tvalid && s1_tvalid) begin
                        w_state_nxt = r_last_gnt ? c_GNT0 : c_GNT1;
                    end else if (s0_tvalid) begin
                        w_state_nxt = c_GNT0;
                    end else if (s1_tvalid) begin
                        w_state_nxt = c_GNT1;
                    end
                end
            end
            c_GNT0:  if (w_done0) w_state_nxt = c_IDLE;
            c_GNT1:  if (w_done1) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            r_state      <= c_IDLE;
            r_last_gnt   <= 1'b1;
            r_starve_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_done0) begin
                r_last_gnt <= 1'b0;
            end else if (w_done1) begin
                r_last_gnt <= 1'b1;
            end
            // Counts LA packets that completed while the user project was waiting.
            if (w_done1) begin
                r_starve_cnt <= 8'd0;
            end else if (w_done0 && s1_tvalid && (r_starve_cnt != 8'hFF)) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            r_m_tdata  <= '0;
            r_m_tstrb  <= '0;
            r_m_tkeep  <= '0;
            r_m_tuser  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tid    <= 1'b0;
        end else if (w_acc0 || w_acc1) begin
            r_m_tdata  <= w_acc1 ? s1_tdata : s0_tdata;
            r_m_tstrb  <= w_acc1 ? s1_tstrb : s0_tstrb;
            r_m_tkeep  <= w_acc1 ? s1_tkeep : s0_tkeep;
            r_m_tuser  <= w_acc1 ? s1_tuser : s0_tuser;
            r_m_tlast  <= w_acc1 ? s1_tlast : s0_tlast;
            r_m_tvalid <= 1'b1;
            r_m_tid    <= w_acc1;
        end else if (m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_tdata     = r_m_tdata;
    assign m_tstrb     = r_m_tstrb;
    assign m_tkeep     = r_m_tkeep;
    assign m_tuser     = r_m_tuser;
    assign m_tlast     = r_m_tlast;
    assign m_tvalid    = r_m_tvalid;
    assign m_tid       = r_m_tid;
    assign grant_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_la_axis_up_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_la_axis_up_arbiter
// Brief    : Scoreboard bench for la_axis_up_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_la_axis_up_arbiter;

    logic        axis_clk = 1'b0;
    logic        axis_rst = 1'b0;
    logic        cfg_arb_en = 1'b0;
    logic [7:0]  cfg_starve_lim = 8'd0;
    logic [31:0] s0_tdata, s1_tdata, m_tdata;
    logic [3:0]  s0_tstrb, s0_tkeep, s1_tstrb, s1_tkeep, m_tstrb, m_tkeep;
    logic [1:0]  s0_tuser, s1_tuser, m_tuser;
    logic        s0_tlast, s0_tvalid, s0_hpri_req, s0_tready;
    logic        s1_tlast, s1_tvalid, s1_tready;
    logic        m_tlast, m_tvalid, m_tid;
    logic        m_tready = 1'b1;
    logic [1:0]  grant_state;

    la_axis_up_arbiter #(.DATA_WIDTH(32), .USER_WIDTH(2)) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst),
        .cfg_arb_en(cfg_arb_en), .cfg_starve_lim(cfg_starve_lim),
        .s0_tdata(s0_tdata), .s0_tstrb(s0_tstrb), .s0_tkeep(s0_tkeep), .s0_tuser(s0_tuser),
        .s0_tlast(s0_tlast), .s0_tvalid(s0_tvalid), .s0_hpri_req(s0_hpri_req), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tstrb(s1_tstrb), .s1_tkeep(s1_tkeep), .s1_tuser(s1_tuser),
        .s1_tlast(s1_tlast), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
        .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tid(m_tid), .m_tready(m_tready),
        .grant_state(grant_state)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct packed {
        logic        tid;
        logic        last;
        logic [1:0]  user;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic [31:0] data;
    } beat_t;

    beat_t       sb_q[$];
    int          obs_order[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    bit          src_on[2];
    int          pkts_left[2];
    int          beat_idx[2];
    int          plen[2];
    logic [31:0] word[2];
    int          in_cnt[2];
    bit          hpri = 1'b0;
    bit          rdy_mode = 1'b0;
    bit          chk_gap = 1'b0;

    int          out_cnt, out_pkts, last_out_cyc;
    bit          out_first;
    logic        cur_tid;
    bit          lat_pend, stall_pend;
    logic [31:0] lat_word;
    beat_t       hold_b;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic beat_t mk_beat(input int x);
        beat_t b;
        b.tid  = (x == 1);
        b.last = (beat_idx[x] == plen[x] - 1);
        b.user = word[x][1:0];
        b.strb = word[x][3:0];
        b.keep = word[x][7:4];
        b.data = word[x];
        return b;
    endfunction

    task automatic drive_inputs();
        beat_t b0, b1;
        b0 = mk_beat(0);
        b1 = mk_beat(1);
        s0_tvalid   = src_on[0] && (pkts_left[0] != 0);
        s0_tdata    = b0.data;  s0_tstrb = b0.strb;  s0_tkeep = b0.keep;
        s0_tuser    = b0.user;  s0_tlast = b0.last;
        s1_tvalid   = src_on[1] && (pkts_left[1] != 0);
        s1_tdata    = b1.data;  s1_tstrb = b1.strb;  s1_tkeep = b1.keep;
        s1_tuser    = b1.user;  s1_tlast = b1.last;
        s0_hpri_req = hpri;
        if (rdy_mode) m_tready = ((cyc % 4) != 3);
    endtask

    task automatic clear_model();
        sb_q.delete();
        obs_order.delete();
        for (int x = 0; x < 2; x++) begin
            src_on[x] = 1'b0; pkts_left[x] = -1; beat_idx[x] = 0; plen[x] = 2; in_cnt[x] = 0;
        end
        hpri = 1'b0; rdy_mode = 1'b0; chk_gap = 1'b0; m_tready = 1'b1;
        out_cnt = 0; out_pkts = 0; last_out_cyc = 0; out_first = 1'b1; cur_tid = 1'b0;
        lat_pend = 1'b0; stall_pend = 1'b0; lat_word = '0;
        drive_inputs();
    endtask

    // One clock: drive at the falling edge, evaluate the handshakes of the coming rising edge.
    task automatic step();
        beat_t e;
        @(negedge axis_clk);
        cyc++;
        drive_inputs();
        #1;
        if (lat_pend) begin
            check("lat_valid", 64'(m_tvalid), 64'd1);
            check("lat_data", 64'(m_tdata), 64'(lat_word));
            lat_pend = 1'b0;
        end
        if (stall_pend) begin
            check("hold_data", 64'(m_tdata), 64'(hold_b.data));
            check("hold_side", 64'({m_tid, m_tlast}), 64'({hold_b.tid, hold_b.last}));
        end
        stall_pend = m_tvalid && !m_tready;
        if (stall_pend) begin
            hold_b.data = m_tdata; hold_b.tid = m_tid; hold_b.last = m_tlast;
            check("stall_rdy", 64'({s0_tready, s1_tready}), 64'd0);
        end
        check("excl_ready", 64'(s0_tready & s1_tready), 64'd0);
        if (m_tvalid && m_tready) begin
            out_cnt++;
            if (sb_q.size() == 0) begin
                check("sb_nonempty", 64'd0, 64'd1);
            end else begin
                e = sb_q.pop_front();
                check("out_data", 64'(m_tdata), 64'(e.data));
                check("out_side", 64'({m_tid, m_tlast, m_tuser, m_tstrb, m_tkeep}),
                      64'({e.tid, e.last, e.user, e.strb, e.keep}));
            end
            if (out_first) begin
                obs_order.push_back(int'(m_tid));
                cur_tid = m_tid;
                if (chk_gap && last_out_cyc > 0) check("pkt_gap", 64'(cyc - last_out_cyc), 64'd2);
            end else begin
                check("pkt_contig", 64'(m_tid), 64'(cur_tid));
                if (chk_gap) check("beat_gap", 64'(cyc - last_out_cyc), 64'd1);
            end
            if (m_tlast) out_pkts++;
            out_first    = m_tlast;
            last_out_cyc = cyc;
        end
        for (int x = 0; x < 2; x++) begin
            logic v, r;
            beat_t b;
            v = (x == 0) ? s0_tvalid : s1_tvalid;
            r = (x == 0) ? s0_tready : s1_tready;
            if (v && r) begin
                b = mk_beat(x);
                sb_q.push_back(b);
                check("gnt_state", 64'(grant_state), (x == 0) ? 64'd1 : 64'd2);
                lat_pend = 1'b1;
                lat_word = b.data;
                in_cnt[x]++;
                word[x] = word[x] + 32'd1;
                if (b.last) begin
                    beat_idx[x] = 0;
                    if (pkts_left[x] > 0) pkts_left[x]--;
                end else begin
                    beat_idx[x]++;
                end
            end
        end
    endtask

    task automatic apply_reset();
        axis_rst = 1'b1;
        #1;
        check("rst_mvalid", 64'(m_tvalid), 64'd0);
        check("rst_mdata", 64'(m_tdata), 64'd0);
        check("rst_mside", 64'({m_tid, m_tlast, m_tuser, m_tstrb, m_tkeep}), 64'd0);
        check("rst_ready", 64'({s0_tready, s1_tready}), 64'd0);
        check("rst_gnt", 64'(grant_state), 64'd0);
        clear_model();
        repeat (2) @(negedge axis_clk);
        axis_rst = 1'b0;
    endtask

    task automatic run_pkts(input int n, input int budget, input string tag);
        int c = 0;
        while (out_pkts < n && c < budget) begin
            step();
            c++;
        end
        check(tag, 64'(out_pkts >= n), 64'd1);
    endtask

    initial begin
        int exp_rr[4] = '{0, 1, 0, 1};
        int exp_st[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int c;

        // Single-source 4-beat packet
        apply_reset();
        cfg_arb_en = 1'b1; cfg_starve_lim = 8'd0;
        src_on[0] = 1'b1; pkts_left[0] = 1; plen[0] = 4; word[0] = 32'h0100_0055;
        run_pkts(1, 40, "t1_timeout");
        repeat (3) step();
        check("t1_words", 64'(out_cnt), 64'd4);
        check("t1_order", 64'(obs_order.size() > 0 ? obs_order[0] : 9), 64'd0);
        check("t1_idle", 64'(grant_state), 64'd0);
        check("t1_mvalid", 64'(m_tvalid), 64'd0);

        // Round-robin with both sources continuously valid
        apply_reset();
        cfg_arb_en = 1'b1; chk_gap = 1'b1;
        src_on[0] = 1'b1; plen[0] = 2; word[0] = 32'h0A00_0000;
        src_on[1] = 1'b1; plen[1] = 2; word[1] = 32'h1B00_0000;
        run_pkts(4, 60, "t2_timeout");
        for (int i = 0; i < 4 && i < obs_order.size(); i++)
            check($sformatf("rr_order%0d", i), 64'(obs_order[i]), 64'(exp_rr[i]));

        // High priority with starvation limit 3
        apply_reset();
        cfg_arb_en = 1'b1; cfg_starve_lim = 8'd3; hpri = 1'b1; chk_gap = 1'b1;
        src_on[0] = 1'b1; plen[0] = 2; word[0] = 32'h3000_0000;
        src_on[1] = 1'b1; plen[1] = 3; word[1] = 32'h3100_0000;
        run_pkts(8, 120, "t3_timeout");
        for (int i = 0; i < 8 && i < obs_order.size(); i++)
            check($sformatf("starve_order%0d", i), 64'(obs_order[i]), 64'(exp_st[i]));

        // High priority with starvation protection off
        apply_reset();
        cfg_arb_en = 1'b1; cfg_starve_lim = 8'd0; hpri = 1'b1;
        src_on[0] = 1'b1; plen[0] = 2; word[0] = 32'h3200_0000;
        src_on[1] = 1'b1; plen[1] = 2; word[1] = 32'h3300_0000;
        run_pkts(6, 80, "t3b_timeout");
        check("t3b_s1_starved", 64'(in_cnt[1]), 64'd0);

        // Back-pressure: m_tready low one cycle in four, 25 packets of 4 words
        apply_reset();
        cfg_arb_en = 1'b1; rdy_mode = 1'b1;
        src_on[0] = 1'b1; pkts_left[0] = 25; plen[0] = 4; word[0] = 32'h2000_0000;
        c = 0;
        while (out_cnt < 100 && c < 1000) begin
            step();
            c++;
        end
        repeat (4) step();
        check("t4_words", 64'(out_cnt), 64'd100);
        check("t4_sb_empty", 64'(sb_q.size()), 64'd0);

        // Reset on the second beat of a user-project packet
        apply_reset();
        cfg_arb_en = 1'b1;
        src_on[1] = 1'b1; pkts_left[1] = 1; plen[1] = 4; word[1] = 32'h5100_0000;
        c = 0;
        while (in_cnt[1] < 2 && c < 40) begin
            step();
            c++;
        end
        @(posedge axis_clk);
        #1;
        check("t5_pre_valid", 64'(m_tvalid), 64'd1);
        apply_reset();
        cfg_arb_en = 1'b1;
        src_on[0] = 1'b1; plen[0] = 2; word[0] = 32'h5000_0000;
        src_on[1] = 1'b1; plen[1] = 2; word[1] = 32'h5200_0000;
        run_pkts(1, 40, "t5_timeout");
        check("t5_first_gnt", 64'(obs_order.size() > 0 ? obs_order[0] : 9), 64'd0);

        // Arbitration disabled in the middle of a user-project packet
        apply_reset();
        cfg_arb_en = 1'b1;
        src_on[1] = 1'b1; plen[1] = 4; word[1] = 32'h6100_0000;
        c = 0;
        while (in_cnt[1] < 1 && c < 40) begin
            step();
            c++;
        end
        cfg_arb_en = 1'b0;
        src_on[0] = 1'b1; plen[0] = 2; word[0] = 32'h6000_0000;
        run_pkts(1, 40, "t6_timeout");
        check("t6_order", 64'(obs_order.size() > 0 ? obs_order[0] : 9), 64'd1);
        repeat (10) begin
            step();
            check("t6_no_gnt", 64'(grant_state), 64'd0);
            check("t6_no_rdy", 64'({s0_tready, s1_tready}), 64'd0);
        end
        cfg_arb_en = 1'b1;
        run_pkts(2, 40, "t6_resume");
        check("t6_resume_gnt", 64'(obs_order.size() > 1 ? obs_order[1] : 9), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/la_axis_up_arbiter.md
Name: la_axis_up_arbiter

Overview:
- Packet-aware arbiter sharing the single upstream AXI-Stream link between two requesters.
- Source 0 is the logic-analyzer trace stream; it has a high-priority request (hpri). Source 1 is the user-project stream.
- Grants are held for a whole packet, up to tlast. Output is registered, with starvation protection for source 1 while source 0 holds hpri.

Parameters:
- pDATA_WIDTH, 32, tdata width; tstrb/tkeep are pDATA_WIDTH/8.
- pUSER_WIDTH, 2, tuser width, passed through unchanged.

Ports:
- axis_clk  in  1  sole clock.
- axis_rst  in  1  reset; asynchronous, active-high.
- cfg_arb_en  in  1  1 = new grants allowed.
- cfg_starve_lim  in  8  max consecutive source-0 packets while source 1 waits; 0 = protection off.
- s0_tdata/s0_tstrb/s0_tkeep/s0_tuser  in  pDATA_WIDTH/pDATA_WIDTH/8/pDATA_WIDTH/8/pUSER_WIDTH  LA beat.
- s0_tlast, s0_tvalid  in  1  LA packet end, valid.
- s0_hpri_req  in  1  LA high-priority request (FIFO above high threshold).
- s0_tready  out  1  LA ready.
- s1_tdata/s1_tstrb/s1_tkeep/s1_tuser/s1_tlast/s1_tvalid  in  as s0  user-project beat.
- s1_tready  out  1  user-project ready.
- m_tdata/m_tstrb/m_tkeep/m_tuser/m_tlast/m_tvalid  out  as s0  upstream beat.
- m_tid  out  1  source of current m_ beat (0 = LA).
- m_tready  in  1  upstream ready.
- grant_state  out  2  00 IDLE, 01 GNT0, 10 GNT1.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - m_tvalid=0; m_tlast=0; m_tdata/tstrb/tkeep/tuser=0; m_tid=0.
  - s0_tready=0; s1_tready=0.
  - State IDLE; last_gnt=1, so source 0 wins the first tie; starve_cnt=0.
- Reset mid-packet: the partial packet is abandoned and the output register is cleared. No tlast is emitted.
- FSM states: IDLE, GNT0, GNT1.
- IDLE, evaluated each cycle only when cfg_arb_en=1:
  - (a) If starve active (cfg_starve_lim!=0, starve_cnt>=cfg_starve_lim, s1_tvalid=1) -> GNT1.
  - (b) Else if s0_tvalid & s0_hpri_req -> GNT0.
  - (c) Else if both valid -> the source != last_gnt (round-robin).
  - (d) Else the single valid source.
  - (e) Else stay IDLE.
- Grant timing: the grant is registered; the source's tready may rise the cycle after the decision.
- GNTx:
  - sx_tready = !m_tvalid | m_tready. The other source's tready=0.
  - An accepted beat (sx_tvalid & sx_tready) loads the output register: m_* <= sx_*, m_tid <= x, m_tvalid <= 1.
  - Without a new accept, a beat with m_tvalid & m_tready clears m_tvalid.
  - Held beat stability: m_tdata/tlast/tid must stay unchanged while m_tvalid=1 and m_tready=0.
- Packet end: an accepted beat with sx_tlast=1 returns the FSM to IDLE on the same edge and sets last_gnt<=x.
- Throughput: one idle arbitration cycle between packets. Within a packet, full rate (1 beat/clk) when m_tready=1.
- starve_cnt, updated on each packet completion:
  - Source-0 packet while s1_tvalid=1: increment, saturating at 255.
  - Source-1 packet: clear to 0.
  - Otherwise: hold.
- cfg_arb_en=0: no new grant. A packet in progress completes, then the FSM idles. The output register still drains.
- hpri asserted mid-packet of source 1: no preemption; source 0 wins at the next IDLE (unless starve active).
- Source tvalid dropping mid-packet: the grant is held; the arbiter waits indefinitely for tlast.
- Latency: source beat to m_tvalid is 1 clk.

Test Plan:
- Only s0 sends 4-beat packets 0x01000055..58 with tlast on beat 4, m_tready=1 -> m_ carries the same 4 words one clk later, m_tid=0, m_tlast on the 4th; grant_state returns to 00.
- Both sources continuously valid with 2-beat packets, hpri=0 -> packet order 0,1,0,1; each packet contiguous; one idle cycle between packets.
- s0_hpri_req=1 held, s1 valid, cfg_starve_lim=3 -> three s0 packets, then one s1 packet, then s0; with cfg_starve_lim=0 s1 never granted.
- m_tready toggled 1-in-4 during an s0 packet -> m_tdata held stable while stalled; s0_tready low whenever m_tvalid & !m_tready; no beat lost or duplicated (scoreboard count = 100 words).
- Reset asserted on the 2nd beat of a 4-beat s1 packet -> all outputs 0 asynchronously; after release, the first grant goes to s0 on a tie.
- cfg_arb_en dropped mid s1 packet -> packet completes with tlast; then no grant while both sources remain valid, until cfg_arb_en=1.
